// File: rtl/instruction_prefetch_register_if.sv
// Prefetch queue / IR handshake bundle between bus, decoder and IR.
// Master drives fetch and request strobes; slave returns IR state.
interface instruction_prefetch_register_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              flush;
  logic              fetch_valid;
  logic              fetch_ready;
  logic [DATA_W-1:0] data_in;
  logic              ir_signal;
  logic              irq_inject;
  logic [DATA_W-1:0] instruction_decode_out;
  logic              ir_valid;
  logic              ir_stall;
  logic [CW-1:0]     queue_count;

  modport master (
    output flush,
    output fetch_valid,
    output data_in,
    output ir_signal,
    output irq_inject,
    input  fetch_ready,
    input  instruction_decode_out,
    input  ir_valid,
    input  ir_stall,
    input  queue_count
  );

  modport slave (
    input  flush,
    input  fetch_valid,
    input  data_in,
    input  ir_signal,
    input  irq_inject,
    output fetch_ready,
    output instruction_decode_out,
    output ir_valid,
    output ir_stall,
    output queue_count
  );
endinterface

// File: rtl/instruction_prefetch_register.sv
// DEPTH-entry prefetch queue feeding a clocked IR, with bypass, stall and BRK.
// Optional stall_cycles counter enabled by defining IR_STALL_CNT_EN.
module instruction_prefetch_register #(
  parameter int              DATA_W     = 8,
  parameter int              DEPTH      = 4,
  parameter logic [DATA_W-1:0] BRK_OPCODE = '0
) (
  input  logic phi2,
  input  logic reset,
  instruction_prefetch_register_if.slave bus
`ifdef IR_STALL_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              valid_q, valid_d;

  logic request;
  logic inject;
  logic have_data;
  logic full;
  logic sel_inj, sel_pop, sel_byp, sel_stall;
  logic push, pop;

  assign request   = bus.ir_signal || (state_q == STALL);
  assign inject    = bus.ir_signal && bus.irq_inject;
  assign have_data = (count != '0);
  assign full      = (count == CW'(DEPTH));

  // Serve selects are one-hot; flush masks them all.
  assign sel_inj   = !bus.flush && request && inject;
  assign sel_pop   = !bus.flush && request && !inject && have_data;
  assign sel_byp   = !bus.flush && request && !inject
                   && !have_data && bus.fetch_valid;
  assign sel_stall = !bus.flush && request && !inject
                   && !have_data && !bus.fetch_valid;

  assign pop  = sel_pop;
  assign push = bus.fetch_valid && !full
              && !bus.flush && !sel_byp;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    unique case (1'b1)
      bus.flush: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
      sel_inj: begin
        state_d = IDLE;
        ir_d    = BRK_OPCODE;
        valid_d = 1'b1;
      end
      sel_pop: begin
        state_d = IDLE;
        ir_d    = mem[rd_ptr];
        valid_d = 1'b1;
      end
      sel_byp: begin
        state_d = IDLE;
        ir_d    = bus.data_in;
        valid_d = 1'b1;
      end
      sel_stall: begin
        state_d = STALL;
        valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge phi2 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= BRK_OPCODE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge phi2 or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge phi2) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

`ifdef IR_STALL_CNT_EN
  always_ff @(posedge phi2 or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (state_q == STALL && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

  assign bus.fetch_ready            = !full;
  assign bus.instruction_decode_out = ir_q;
  assign bus.ir_valid               = valid_q;
  assign bus.ir_stall               = (state_q == STALL);
  assign bus.queue_count            = count;

endmodule

// File: tb/tb_instruction_prefetch_register.sv
// Directed bench for instruction_prefetch_register (DEPTH 4, DATA_W 8).
// Set IR_STALL_CNT_EN to also exercise the stall counter.
module tb_instruction_prefetch_register;

  logic phi2;
  logic reset;
  int   n_chk;
  int   n_fail;

  instruction_prefetch_register_if #(.DATA_W(8), .DEPTH(4)) bus ();

`ifdef IR_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  instruction_prefetch_register #(
    .DATA_W(8),
    .DEPTH(4),
    .BRK_OPCODE(8'h00)
  ) dut (
    .phi2(phi2),
    .reset(reset),
    .bus(bus)
`ifdef IR_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge phi2);
    #1;
  endtask

  task automatic idle();
    bus.flush       = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.data_in     = 8'h00;
    bus.ir_signal   = 1'b0;
    bus.irq_inject  = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    bus.fetch_valid = 1'b1;
    bus.data_in     = b;
    tick();
    bus.fetch_valid = 1'b0;
  endtask

  task automatic pull();
    bus.ir_signal = 1'b1;
    tick();
    bus.ir_signal = 1'b0;
  endtask

  logic [7:0] seq [4];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    idle();
    reset = 1'b1;
    #2;
    chk("rst_ir",    32'(bus.instruction_decode_out), 32'h00);
    chk("rst_valid", 32'(bus.ir_valid),    32'd0);
    chk("rst_stall", 32'(bus.ir_stall),    32'd0);
    chk("rst_count", 32'(bus.queue_count), 32'd0);
    chk("rst_ready", 32'(bus.fetch_ready), 32'd1);
    tick();
    reset = 1'b0;

    // fill to full
    seq[0] = 8'hA9; seq[1] = 8'h05;
    seq[2] = 8'h8D; seq[3] = 8'h00;
    for (int i = 0; i < 4; i++) push(seq[i]);
    chk("full_count", 32'(bus.queue_count), 32'd4);
    chk("full_ready", 32'(bus.fetch_ready), 32'd0);
    push(8'h60);
    chk("rej_count", 32'(bus.queue_count), 32'd4);
    // full + pop same edge: no push
    bus.fetch_valid = 1'b1;
    bus.data_in     = 8'h60;
    pull();
    bus.fetch_valid = 1'b0;
    chk("pop_ir",    32'(bus.instruction_decode_out), 32'hA9);
    chk("pop_count", 32'(bus.queue_count), 32'd3);
    chk("pop_valid", 32'(bus.ir_valid),    32'd1);
    for (int i = 1; i < 4; i++) begin
      pull();
      chk("drain_ir", 32'(bus.instruction_decode_out), 32'(seq[i]));
    end
    chk("drain_count", 32'(bus.queue_count), 32'd0);

    // bypass on empty
    bus.fetch_valid = 1'b1;
    bus.data_in     = 8'hEA;
    pull();
    bus.fetch_valid = 1'b0;
    chk("byp_ir",    32'(bus.instruction_decode_out), 32'hEA);
    chk("byp_valid", 32'(bus.ir_valid),    32'd1);
    chk("byp_count", 32'(bus.queue_count), 32'd0);
    tick();
    chk("valid_hold", 32'(bus.ir_valid), 32'd1);

    // stall then auto-retry
    pull();
    chk("stl_stall", 32'(bus.ir_stall), 32'd1);
    chk("stl_valid", 32'(bus.ir_valid), 32'd0);
    bus.irq_inject = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.irq_inject = 1'b0;
    chk("stl_hold", 32'(bus.ir_stall), 32'd1);
    chk("stl_ir",   32'(bus.instruction_decode_out), 32'hEA);
    push(8'h4C);
    chk("rty_ir",    32'(bus.instruction_decode_out), 32'h4C);
    chk("rty_stall", 32'(bus.ir_stall),    32'd0);
    chk("rty_valid", 32'(bus.ir_valid),    32'd1);
    chk("rty_count", 32'(bus.queue_count), 32'd0);

    // push and pop on one edge
    push(8'h11);
    bus.fetch_valid = 1'b1;
    bus.data_in     = 8'h22;
    pull();
    bus.fetch_valid = 1'b0;
    chk("pp_ir",    32'(bus.instruction_decode_out), 32'h11);
    chk("pp_count", 32'(bus.queue_count), 32'd1);
    pull();
    chk("pp_ir2", 32'(bus.instruction_decode_out), 32'h22);

    // inject and flush
    push(8'h18);
    push(8'h69);
    bus.irq_inject = 1'b1;
    tick();
    chk("irq_alone", 32'(bus.instruction_decode_out), 32'h22);
    pull();
    bus.irq_inject = 1'b0;
    chk("irq_ir",    32'(bus.instruction_decode_out), 32'h00);
    chk("irq_count", 32'(bus.queue_count), 32'd2);
    chk("irq_valid", 32'(bus.ir_valid),    32'd1);
    bus.flush       = 1'b1;
    bus.fetch_valid = 1'b1;
    bus.data_in     = 8'h77;
    pull();
    bus.flush       = 1'b0;
    bus.fetch_valid = 1'b0;
    chk("fl_count", 32'(bus.queue_count), 32'd0);
    chk("fl_valid", 32'(bus.ir_valid),    32'd0);
    chk("fl_ir",    32'(bus.instruction_decode_out), 32'h00);
    pull();
    chk("fl_empty", 32'(bus.ir_stall), 32'd1);

    // async reset mid-stall
    #2;
    reset = 1'b1;
    #1;
    chk("ar_stall", 32'(bus.ir_stall), 32'd0);
    tick();
    reset = 1'b0;

`ifdef IR_STALL_CNT_EN
    chk("sc_rst", 32'(stall_cycles), 32'd0);
    pull();
    for (int i = 0; i < 4; i++) tick();
    push(8'h33);
    chk("sc_five", 32'(stall_cycles), 32'd5);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("sc_flush", 32'(stall_cycles), 32'd5);
    reset = 1'b1;
    #1;
    chk("sc_reset", 32'(stall_cycles), 32'd0);
    tick();
    reset = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
